// File: rtl/exp_arb_pkg.sv
// rtl/exp_arb_pkg.sv - shared types and constants for the exponential-unit arbiter
package exp_arb_pkg;

    localparam int X_W    = 16;
    localparam int INT_W  = 2;
    localparam int FRAC_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Index width for n items; never less than one bit so vectors stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/exp_rr_picker.sv
// rtl/exp_rr_picker.sv - round-robin search: first set request at or after rr_ptr
module exp_rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = exp_arb_pkg::clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W:0] pos;

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        any       = 1'b0;
        grant_idx = '0;
        pos       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(N_REQ)) begin
                pos = pos - (IDX_W + 1)'(N_REQ);
            end
            if (req[pos[IDX_W-1:0]]) begin
                any       = 1'b1;
                grant_idx = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/exp_arbiter.sv
// rtl/exp_arbiter.sv - round-robin sharing of one exponential unit between requesters
module exp_arbiter #(
    parameter int N_REQ   = 4,
    parameter int X_W     = exp_arb_pkg::X_W,
    parameter int FRAC_W  = exp_arb_pkg::FRAC_W,
    parameter int INT_W   = exp_arb_pkg::INT_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*X_W-1:0]   x_in,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [INT_W-1:0]       rsp_intpart,
    output logic [FRAC_W-1:0]      rsp_fracpart,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   exp_start,
    output logic [X_W-1:0]         exp_x,
    input  logic                   exp_done,
    input  logic [INT_W-1:0]       exp_intpart,
    input  logic [FRAC_W-1:0]      exp_fracpart
);

    import exp_arb_pkg::*;

    localparam int IDX_W = clog2(N_REQ);
    localparam int WD_W  = clog2(TIMEOUT);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [WD_W-1:0]    wd, wd_nxt;
    logic               done_q;
    logic               done_rise;

    logic [X_W-1:0]     x_nxt;
    logic [INT_W-1:0]   int_nxt;
    logic [FRAC_W-1:0]  frac_nxt;
    logic               err_nxt;
    logic [N_REQ-1:0]   ack_nxt;
    logic [N_REQ-1:0]   rsp_valid_nxt;
    logic               start_nxt;
    logic               busy_nxt;

    logic               any;
    logic [IDX_W-1:0]   grant_idx;
    logic [X_W-1:0]     x_sel;
    logic [N_REQ-1:0]   gnt_oh;
    logic [N_REQ-1:0]   own_oh;

    exp_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .any       (any),
        .grant_idx (grant_idx)
    );

    // Only a fresh rising edge of done completes; a level left from an earlier op is ignored.
    assign done_rise = exp_done & ~done_q;

    // Operand mux and one-hot decodes of the candidate grant and current owner.
    always_comb begin
        x_sel  = '0;
        gnt_oh = '0;
        own_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                x_sel     = x_in[i*X_W +: X_W];
                gnt_oh[i] = 1'b1;
            end
            if (owner == IDX_W'(i)) begin
                own_oh[i] = 1'b1;
            end
        end
    end

    // Next-state and next-output decode; every output is registered from these.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        wd_nxt     = wd;
        x_nxt      = exp_x;
        int_nxt    = rsp_intpart;
        frac_nxt   = rsp_fracpart;
        err_nxt    = rsp_err;
        ack_nxt    = '0;
        start_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (any) begin
                    x_nxt     = x_sel;
                    owner_nxt = grant_idx;
                    ack_nxt   = gnt_oh;
                    start_nxt = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                wd_nxt    = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    int_nxt   = exp_intpart;
                    frac_nxt  = exp_fracpart;
                    err_nxt   = 1'b0;
                    state_nxt = RESP;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    int_nxt   = '0;
                    frac_nxt  = '0;
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    wd_nxt = wd + 1'b1;
                end
            end
            RESP: begin
                rr_ptr_nxt = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt      = (state_nxt != IDLE);
        rsp_valid_nxt = (state_nxt == RESP) ? own_oh : '0;
    end

    // State, datapath and output registers; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            wd           <= '0;
            done_q       <= 1'b0;
            exp_x        <= '0;
            exp_start    <= 1'b0;
            ack          <= '0;
            rsp_valid    <= '0;
            rsp_intpart  <= '0;
            rsp_fracpart <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            owner        <= owner_nxt;
            wd           <= wd_nxt;
            done_q       <= exp_done;
            exp_x        <= x_nxt;
            exp_start    <= start_nxt;
            ack          <= ack_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_intpart  <= int_nxt;
            rsp_fracpart <= frac_nxt;
            rsp_err      <= err_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_exp_arbiter.sv
// tb/tb_exp_arbiter.sv - directed self-checking bench for exp_arbiter with an exponential stub
module tb_exp_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0;
    logic [63:0] x_in = 64'b0;
    logic [3:0]  ack;
    logic [3:0]  rsp_valid;
    logic [1:0]  rsp_intpart;
    logic [15:0] rsp_fracpart;
    logic        rsp_err;
    logic        busy;
    logic        exp_start;
    logic [15:0] exp_x;
    logic        exp_done;
    logic [1:0]  exp_intpart;
    logic [15:0] exp_fracpart;

    logic [15:0] stub_x;
    int          cnt;
    int          dly   = 10;
    bit          stale = 1'b0;
    bit          never = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    exp_arbiter #(
        .N_REQ   (4),
        .X_W     (16),
        .FRAC_W  (16),
        .INT_W   (2),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .x_in         (x_in),
        .ack          (ack),
        .rsp_valid    (rsp_valid),
        .rsp_intpart  (rsp_intpart),
        .rsp_fracpart (rsp_fracpart),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .exp_start    (exp_start),
        .exp_x        (exp_x),
        .exp_done     (exp_done),
        .exp_intpart  (exp_intpart),
        .exp_fracpart (exp_fracpart)
    );

    always #5 clk = ~clk;

    // Stub unit: done rises dly cycles after start; result is intpart=1, fracpart=x.
    assign exp_intpart  = 2'd1;
    assign exp_fracpart = stub_x;

    always @(posedge clk) begin
        if (rst) begin
            exp_done <= 1'b0;
            cnt      <= 0;
            stub_x   <= 16'd0;
        end else if (exp_start) begin
            cnt    <= 1;
            stub_x <= exp_x;
            if (!stale) exp_done <= 1'b0;
        end else if (cnt != 0) begin
            cnt <= cnt + 1;
            if (stale && cnt == dly / 2) exp_done <= 1'b0;
            if (!never && cnt == dly - 1) exp_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    // Requests are already driven; wait for the grant, drop it, then wait for the response.
    task automatic run_op(input logic [3:0] eoh, input int eack_lat, input logic [15:0] ex,
                          input logic [1:0] eint, input logic [15:0] efrac, input logic eerr,
                          input int elat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0 && n < 100);
        chk("ack_lat", n, eack_lat);
        chk("ack_oh", ack, eoh);
        chk("exp_start", exp_start, 1);
        chk("exp_x", exp_x, ex);
        chk("busy_on", busy, 1);
        req = req & ~ack;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("start_pulse", {ack, exp_start}, 0);
        end while (rsp_valid == 4'b0 && n < 100);
        chk("rsp_lat", n, elat);
        chk("rsp_oh", rsp_valid, eoh);
        chk("rsp_int", rsp_intpart, eint);
        chk("rsp_frac", rsp_fracpart, efrac);
        chk("rsp_err", rsp_err, eerr);
    endtask

    initial begin
        int n;

        // Reset state and single request
        do_reset();
        chk("rst_ack", ack, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", exp_start, 0);
        chk("rst_exp_x", exp_x, 0);
        chk("rst_rsp", {rsp_err, rsp_intpart, rsp_fracpart}, 0);
        tick(2);
        chk("idle_busy", busy, 0);
        x_in = {16'd400, 16'd300, 16'd200, 16'd10};
        req  = 4'b0001;
        run_op(4'b0001, 1, 16'd10, 2'd1, 16'd10, 1'b0, 11);
        tick(1);
        chk("after_resp", {busy, rsp_valid}, 0);
        chk("rsp_hold", rsp_fracpart, 16'd10);

        // Contention from rr_ptr=0: 0,1,2,3 with one idle cycle between ops
        do_reset();
        x_in = {16'd400, 16'd300, 16'd200, 16'd100};
        req  = 4'b1111;
        run_op(4'b0001, 1, 16'd100, 2'd1, 16'd100, 1'b0, 11);
        run_op(4'b0010, 2, 16'd200, 2'd1, 16'd200, 1'b0, 11);
        run_op(4'b0100, 2, 16'd300, 2'd1, 16'd300, 1'b0, 11);
        run_op(4'b1000, 2, 16'd400, 2'd1, 16'd400, 1'b0, 11);

        // Round-robin wrap
        tick(2);
        req = 4'b0100;
        run_op(4'b0100, 1, 16'd300, 2'd1, 16'd300, 1'b0, 11);
        tick(2);
        req = 4'b0101;
        run_op(4'b0001, 1, 16'd100, 2'd1, 16'd100, 1'b0, 11);
        run_op(4'b0100, 2, 16'd300, 2'd1, 16'd300, 1'b0, 11);
        tick(2);
        req = 4'b1001;
        run_op(4'b1000, 1, 16'd400, 2'd1, 16'd400, 1'b0, 11);
        run_op(4'b0001, 2, 16'd100, 2'd1, 16'd100, 1'b0, 11);

        // Stale done level stays high into the next op
        stale = 1'b1;
        tick(2);
        req = 4'b0010;
        run_op(4'b0010, 1, 16'd200, 2'd1, 16'd200, 1'b0, 11);
        stale = 1'b0;

        // Done rise on the same cycle as the timeout: done wins
        dly = 16;
        tick(2);
        req = 4'b0001;
        run_op(4'b0001, 1, 16'd100, 2'd1, 16'd100, 1'b0, 17);

        // Timeout with no done, then a normal op
        dly   = 10;
        never = 1'b1;
        tick(2);
        req = 4'b0010;
        run_op(4'b0010, 1, 16'd200, 2'd0, 16'd0, 1'b1, 17);
        never = 1'b0;
        tick(2);
        req = 4'b1000;
        run_op(4'b1000, 1, 16'd400, 2'd1, 16'd400, 1'b0, 11);

        // Reset mid-op with rr_ptr=3 beforehand
        tick(2);
        req = 4'b0100;
        run_op(4'b0100, 1, 16'd300, 2'd1, 16'd300, 1'b0, 11);
        never = 1'b1;
        tick(2);
        req = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0 && n < 100);
        chk("mid_ack", ack, 4'b0001);
        req = 4'b0;
        tick(5);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_outs", {ack, exp_start, exp_x, rsp_err, rsp_intpart, rsp_fracpart}, 0);
        rst   = 1'b0;
        never = 1'b0;
        req   = 4'b1100;
        run_op(4'b0100, 1, 16'd300, 2'd1, 16'd300, 1'b0, 11);
        req = 4'b0;
        tick(3);
        chk("withdraw_idle", {busy, ack}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exp_arbiter.md
Name: exp_arbiter

Overview:
Shares one `exponential` unit (start/x/done/intpart/fracpart, e^x with x in unsigned 0.16 fixed point, result 2.16) between N_REQ requesters. Round-robin arbitration grants one requester at a time. The block latches the granted operand, pulses the unit's start and waits for done. It then returns the result to the owner with a one-cycle valid, and a watchdog aborts hung operations. It sits between the requesting datapaths and a single `exponential` instance, and both share clk/rst.

Parameters:
N_REQ, 4, number of requesters (2..8)
X_W, 16, operand width (matches exponential x)
FRAC_W, 16, fractional result width
INT_W, 2, integer result width
TIMEOUT, 1024, max WAIT cycles before abort (>=4)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request level
x_in  in  N_REQ*X_W  operands, requester i at [i*X_W +: X_W]
ack  out  N_REQ  one-hot one-cycle pulse: request accepted, operand captured
rsp_valid  out  N_REQ  one-hot one-cycle pulse: result for requester i
rsp_intpart  out  INT_W  result integer part, valid with rsp_valid
rsp_fracpart  out  FRAC_W  result fractional part, valid with rsp_valid
rsp_err  out  1  timeout flag, valid with rsp_valid
busy  out  1  high in any state but IDLE
exp_start  out  1  to exponential.start
exp_x  out  X_W  to exponential.x, held stable from START until next grant
exp_done  in  1  from exponential.done (level; may stay high after completion)
exp_intpart  in  INT_W  from exponential.intpart
exp_fracpart  in  FRAC_W  from exponential.fracpart

Behaviour:
- Reset state: state=IDLE, rr_ptr=0, owner=0, all outputs 0 (ack, rsp_valid, rsp_*, busy, exp_start, exp_x), wd counter 0, done_q=0.
- All outputs registered. Reset asserted mid-operation returns to IDLE next edge, and the in-flight result is dropped with no rsp_valid. The shared rst also resets the exponential unit.
- States:
  - IDLE: if any req bit is set, pick g = first set bit searching from rr_ptr upward, wrapping modulo N_REQ. Capture exp_x<=x_in[g], owner<=g, go START. Otherwise stay.
  - START (1 cycle): exp_start=1, ack[g]=1, busy=1, wd<=0, go WAIT.
  - WAIT: exp_start=0. done_rise = exp_done & ~done_q (done_q registers exp_done every cycle). Completion is detected only on done_rise, so a done level left over from a previous op is ignored.
    - On done_rise: latch exp_intpart/exp_fracpart, rsp_err<=0, go RESP.
    - Else if wd==TIMEOUT-1: rsp_intpart/rsp_fracpart<=0, rsp_err<=1, go RESP.
    - Otherwise wd<=wd+1.
    - If done_rise and timeout coincide, done wins (err=0).
  - RESP (1 cycle): rsp_valid[owner]=1, rsp_* held. rr_ptr<=(owner+1) mod N_REQ. Go IDLE.
- rsp_* data holds its value until the next RESP; only rsp_valid pulses.
- Latency:
  - IDLE with req seen at edge t: ack and exp_start are high in cycle t+1.
  - exp_done rising observed at edge d: rsp_valid is high in cycle d+1.
  - Minimum back-to-back turnaround is 1 IDLE cycle between RESP and the next START.
- Requester rules:
  - Hold req high and x_in stable until ack.
  - Drop req in the ack cycle or re-request. A req still high after ack is treated as a new request.
  - Deassertion before grant withdraws the request without error.
- Fairness: a requester holding req continuously is granted within N_REQ operations.
- Only one operation is outstanding at any time. exp_start never pulses outside START.

Decomposition:
- Package exp_arb_pkg: state enum {IDLE, START, WAIT, RESP} (2-bit), width constants X_W/INT_W/FRAC_W, and index width function clog2(N_REQ).
- Sub-module exp_rr_picker (combinational): inputs req, rr_ptr; outputs any, grant_idx. Parameterised on N_REQ.
- The top module holds the FSM, operand/result registers, done edge detector and watchdog.

Test Plan:
Use the real exponential or a stub with done rising 20 cycles after start, returning intpart=1, fracpart=x.
- Single request: rst 3 cycles, then req=4'b0001, x0=16'd10 → ack[0] next cycle with exp_start=1, exp_x=10. rsp_valid[0] 1 cycle after done rises. Real unit gives intpart=1, fracpart≈10; rsp_err=0.
- Contention: req=4'b1111, x_i=100*(i+1), held until each ack → grants in order 0,1,2,3 and responses in that order. With the stub, fracpart=100,200,300,400.
- Round-robin wrap: after serving 2, assert req=4'b0101 → grant 0, then 2. With rr_ptr=3 and req=4'b1001 → grant 3 first, then 0.
- Stale done: the stub keeps done high after the first op; issue a second request → no premature rsp_valid. Completion occurs only after the new done rise.
- Timeout: TIMEOUT=16, stub never raises done → rsp_valid[owner] 16 cycles into WAIT with rsp_err=1 and data 0. Then IDLE, and the next request is served normally.
- Reset mid-op: assert rst 5 cycles into WAIT → next cycle all outputs 0, busy=0, no rsp_valid. A subsequent req on requester 2 is granted (rr_ptr back to 0, search from 0).
